// File: rtl/config_loader.sv
// Serial configuration-chain loader: takes host words over a valid/ready port,
// shifts them LSB first into a scan-style chain and collects the bits it returns.
module config_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic              config_clk,
    input  logic              config_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_out,
    output logic              cfg_en,
    input  logic              cfg_ret,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int CW        = $clog2(CHAIN_LEN + 1);
    localparam int WW        = $clog2(WORD_W + 1);
    localparam int LAST_BITS = CHAIN_LEN % WORD_W;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CHAIN_LEN - 1);
    localparam logic [WW-1:0] WBIT_LAST = WW'(WORD_W - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_WORD = 2'd1;
    localparam logic [1:0] S_SHIFT     = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [WORD_W-1:0] word_q,     word_d;
    logic [CW-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [WW-1:0]     wbit_q,     wbit_d;
    logic              cfg_out_q,  cfg_out_d;
    logic              cfg_en_q,   cfg_en_d;
    logic [WORD_W-2:0] rb_shift_q, rb_shift_d;
    logic [WORD_W-1:0] rb_data_q,  rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              done_q,     done_d;

    logic [WORD_W-1:0] rb_word;
    logic              last_chain;
    logic              last_word;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        bit_cnt_d  = bit_cnt_q;
        wbit_d     = wbit_q;
        cfg_out_d  = cfg_out_q;
        cfg_en_d   = 1'b0;
        rb_shift_d = rb_shift_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        done_d     = 1'b0;

        // Returned bits enter at the top so the first one ends up at bit 0.
        rb_word    = {cfg_ret, rb_shift_q};
        last_chain = (bit_cnt_q == CNT_LAST);
        last_word  = (wbit_q == WBIT_LAST) || last_chain;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_WAIT_WORD;
                end
            end
            S_WAIT_WORD: begin
                // cfg_en/cfg_out are registered, so the first bit is set up on the accept edge.
                if (s_valid) begin
                    state_d   = S_SHIFT;
                    cfg_en_d  = 1'b1;
                    cfg_out_d = s_data[0];
                    word_d    = s_data >> 1;
                    wbit_d    = '0;
                end
            end
            S_SHIFT: begin
                rb_shift_d = rb_word[WORD_W-1:1];
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (last_word) begin
                    rb_valid_d = 1'b1;
                    // A short final word is right-aligned so its unused upper bits read as 0.
                    if (last_chain && (LAST_BITS != 0) && (wbit_q != WBIT_LAST)) begin
                        rb_data_d = rb_word >> (WORD_W - LAST_BITS);
                    end else begin
                        rb_data_d = rb_word;
                    end
                    if (last_chain) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_WORD;
                    end
                end else begin
                    cfg_en_d  = 1'b1;
                    cfg_out_d = word_q[0];
                    word_d    = word_q >> 1;
                    wbit_d    = wbit_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                wbit_d    = '0;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            cfg_en_d   = 1'b0;
            cfg_out_d  = cfg_out_q;
            rb_data_d  = rb_data_q;
            rb_valid_d = 1'b0;
            done_d     = 1'b0;
            bit_cnt_d  = '0;
            wbit_d     = '0;
        end
    end

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            bit_cnt_q  <= '0;
            wbit_q     <= '0;
            cfg_out_q  <= 1'b0;
            cfg_en_q   <= 1'b0;
            rb_shift_q <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            bit_cnt_q  <= bit_cnt_d;
            wbit_q     <= wbit_d;
            cfg_out_q  <= cfg_out_d;
            cfg_en_q   <= cfg_en_d;
            rb_shift_q <= rb_shift_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
            done_q     <= done_d;
        end
    end

    assign s_ready  = (state_q == S_WAIT_WORD);
    assign busy     = (state_q != S_IDLE);
    assign cfg_out  = cfg_out_q;
    assign cfg_en   = cfg_en_q;
    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 16-bit and a 12-bit chain, each with a
// behavioural shift-register model on the serial side.
module tb_config_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready, cfg_out, cfg_en, cfg_ret, rb_valid, busy, done;
    logic [7:0] rb_data;

    logic       start12 = 1'b0, abort12 = 1'b0, s_valid12 = 1'b0;
    logic [7:0] s_data12 = '0;
    logic       s_ready12, cfg_out12, cfg_en12, cfg_ret12, rb_valid12, busy12, done12;
    logic [7:0] rb_data12;

    config_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
        .config_clk(clk), .config_rst_n(rst_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cfg_out(cfg_out), .cfg_en(cfg_en), .cfg_ret(cfg_ret),
        .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done)
    );

    config_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
        .config_clk(clk), .config_rst_n(rst_n), .start(start12), .abort(abort12),
        .s_data(s_data12), .s_valid(s_valid12), .s_ready(s_ready12),
        .cfg_out(cfg_out12), .cfg_en(cfg_en12), .cfg_ret(cfg_ret12),
        .rb_data(rb_data12), .rb_valid(rb_valid12), .busy(busy12), .done(done12)
    );

    // Chain models: serial in at the top, serial out from bit 0, no reset.
    logic [15:0] chain16 = '0;
    logic [11:0] chain12 = '0;
    always @(posedge clk) if (cfg_en) chain16 <= {cfg_out, chain16[15:1]};
    always @(posedge clk) if (cfg_en12) chain12 <= {cfg_out12, chain12[11:1]};
    assign cfg_ret   = chain16[0];
    assign cfg_ret12 = chain12[0];

    int         en_cnt = 0, done_cnt = 0, en_cnt12 = 0, done_cnt12 = 0;
    logic       bitq[$];
    logic [7:0] rbq[$];
    logic       bitq12[$];
    logic [7:0] rbq12[$];

    always @(negedge clk) begin
        if (cfg_en) begin en_cnt++; bitq.push_back(cfg_out); end
        if (done) done_cnt++;
        if (rb_valid) rbq.push_back(rb_data);
        if (cfg_en12) begin en_cnt12++; bitq12.push_back(cfg_out12); end
        if (done12) done_cnt12++;
        if (rb_valid12) rbq12.push_back(rb_data12);
    end

    int n_cmp = 0, n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept16();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (s_ready) ok = 1'b1;
            tick();
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL accept16_timeout: s_ready=%0b required 1", s_ready); end
    endtask

    task automatic wait_done16(input int d0);
        for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
        tick();
        tick();
        n_cmp++;
        if (done_cnt == d0) begin n_fail++; $display("FAIL done16_timeout: done pulses=0 required >=1"); end
    endtask

    task automatic load16(input logic [7:0] w0, input logic [7:0] w1, input int gap);
        int   d0;
        logic held;
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        s_data = w0; s_valid = 1'b1;
        accept16();
        if (gap > 0) begin
            s_valid = 1'b0;
            for (int i = 0; i < 40 && !s_ready; i++) tick();
            held = cfg_out;
            for (int i = 0; i < gap; i++) begin
                n_cmp++;
                if ({cfg_en, cfg_out} !== {1'b0, held}) begin
                    n_fail++;
                    $display("FAIL gap_idle[%0d]: en,out=%0b%0b required 0%0b", i, cfg_en, cfg_out, held);
                end
                tick();
            end
            s_valid = 1'b1;
        end
        s_data = w1;
        accept16();
        s_valid = 1'b0;
        wait_done16(d0);
    endtask

    function automatic logic [15:0] bits16(input int b0);
        logic [15:0] v = 'x;
        if (bitq.size() >= b0 + 16) for (int i = 0; i < 16; i++) v[i] = bitq[b0 + i];
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; #1;
        rst_n = 1'b0; #2;
        n_cmp++;
        if ({s_ready, cfg_out, cfg_en, rb_data, rb_valid, busy, done} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset16_outputs: got %h required 0", {s_ready, cfg_out, cfg_en, rb_data, rb_valid, busy, done});
        end
        n_cmp++;
        if ({s_ready12, cfg_out12, cfg_en12, rb_data12, rb_valid12, busy12, done12} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset12_outputs: got %h required 0", {s_ready12, cfg_out12, cfg_en12, rb_data12, rb_valid12, busy12, done12});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int e0 = en_cnt, d0 = done_cnt, b0 = bitq.size();
        load16(8'hA5, 8'h3C, 0);
        n_cmp++;
        if (en_cnt - e0 !== 16) begin n_fail++; $display("FAIL basic_en_cycles: got %0d required 16", en_cnt - e0); end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done: got %0d required 1", done_cnt - d0); end
        n_cmp++;
        if (bits16(b0) !== 16'h3CA5) begin n_fail++; $display("FAIL basic_bits: got %h required 3ca5", bits16(b0)); end
        n_cmp++;
        if (chain16 !== 16'h3CA5) begin n_fail++; $display("FAIL basic_chain: got %h required 3ca5", chain16); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %0b required 0", busy); end
    endtask

    task automatic test_readback();
        int r0 = rbq.size();
        load16(8'h00, 8'h00, 0);
        n_cmp++;
        if (rbq.size() - r0 !== 2) begin n_fail++; $display("FAIL rb_count: got %0d required 2", rbq.size() - r0); end
        if (rbq.size() - r0 >= 2) begin
            n_cmp++;
            if (rbq[r0] !== 8'hA5) begin n_fail++; $display("FAIL rb_word0: got %h required a5", rbq[r0]); end
            n_cmp++;
            if (rbq[r0 + 1] !== 8'h3C) begin n_fail++; $display("FAIL rb_word1: got %h required 3c", rbq[r0 + 1]); end
        end
        n_cmp++;
        if (chain16 !== 16'h0000) begin n_fail++; $display("FAIL rb_chain_cleared: got %h required 0000", chain16); end
    endtask

    task automatic test_gap();
        int e0 = en_cnt, d0 = done_cnt, b0 = bitq.size();
        load16(8'h5A, 8'hC3, 5);
        n_cmp++;
        if (en_cnt - e0 !== 16) begin n_fail++; $display("FAIL gap_en_cycles: got %0d required 16", en_cnt - e0); end
        n_cmp++;
        if (bits16(b0) !== 16'hC35A) begin n_fail++; $display("FAIL gap_bits: got %h required c35a", bits16(b0)); end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL gap_done: got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        int e0 = en_cnt, d0 = done_cnt, r0 = rbq.size(), b0;
        start = 1'b1; tick(); start = 1'b0;
        s_data = 8'hFF; s_valid = 1'b1;
        accept16();
        s_valid = 1'b0;
        repeat (5) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++;
        if ({cfg_en, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_en_busy: got %b required 00", {cfg_en, busy}); end
        repeat (3) tick();
        n_cmp++;
        if (en_cnt - e0 !== 6) begin n_fail++; $display("FAIL abort_shifts: got %0d required 6", en_cnt - e0); end
        n_cmp++;
        if ({done_cnt - d0, rbq.size() - r0} !== {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL abort_no_done_rb: done=%0d rb=%0d required 0 0", done_cnt - d0, rbq.size() - r0);
        end
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: busy=%0b required 0", busy); end
        start = 1'b1; tick(); start = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++;
        if ({busy, s_ready} !== 2'b00) begin n_fail++; $display("FAIL abort_in_wait: got %b required 00", {busy, s_ready}); end
        // Clean load with extra start pulses while busy.
        e0 = en_cnt; d0 = done_cnt; b0 = bitq.size();
        start = 1'b1; tick(); start = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL start_in_wait: s_ready=%0b required 1", s_ready); end
        s_data = 8'hA5; s_valid = 1'b1;
        accept16();
        s_data = 8'h3C;
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        accept16();
        s_valid = 1'b0;
        wait_done16(d0);
        repeat (3) tick();
        n_cmp++;
        if (en_cnt - e0 !== 16) begin n_fail++; $display("FAIL busy_start_en: got %0d required 16", en_cnt - e0); end
        n_cmp++;
        if (bits16(b0) !== 16'h3CA5) begin n_fail++; $display("FAIL busy_start_bits: got %h required 3ca5", bits16(b0)); end
        n_cmp++;
        if ({done_cnt - d0, 31'd0, busy} !== {32'd1, 32'd0}) begin
            n_fail++; $display("FAIL busy_start_done_idle: done=%0d busy=%0b required 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int e0, d0, b0;
        start = 1'b1; tick(); start = 1'b0;
        s_data = 8'hFF; s_valid = 1'b1;
        accept16();
        s_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({s_ready, cfg_out, cfg_en, rb_data, rb_valid, busy, done} !== 14'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h required 0", {s_ready, cfg_out, cfg_en, rb_data, rb_valid, busy, done});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_needs_start: busy=%0b required 0", busy); end
        e0 = en_cnt; d0 = done_cnt; b0 = bitq.size();
        load16(8'hA5, 8'h3C, 0);
        n_cmp++;
        if (en_cnt - e0 !== 16) begin n_fail++; $display("FAIL midreset_reload_en: got %0d required 16", en_cnt - e0); end
        n_cmp++;
        if (bits16(b0) !== 16'h3CA5) begin n_fail++; $display("FAIL midreset_reload_bits: got %h required 3ca5", bits16(b0)); end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midreset_reload_done: got %0d required 1", done_cnt - d0); end
    endtask

    task automatic load12(input logic [7:0] w0, input logic [7:0] w1);
        int d0 = done_cnt12;
        bit ok;
        start12 = 1'b1; tick(); start12 = 1'b0;
        s_valid12 = 1'b1;
        for (int w = 0; w < 2; w++) begin
            s_data12 = (w == 0) ? w0 : w1;
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                if (s_ready12) ok = 1'b1;
                tick();
            end
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL accept12_timeout[%0d]: s_ready=%0b required 1", w, s_ready12); end
        end
        s_valid12 = 1'b0;
        for (int i = 0; i < 60 && done_cnt12 == d0; i++) tick();
        tick(); tick();
        n_cmp++;
        if (done_cnt12 - d0 !== 1) begin n_fail++; $display("FAIL done12: got %0d required 1", done_cnt12 - d0); end
    endtask

    task automatic test_chain12();
        int          e0 = en_cnt12, b0 = bitq12.size(), r0;
        logic [11:0] v = 'x;
        load12(8'hFF, 8'hFF);
        n_cmp++;
        if (en_cnt12 - e0 !== 12) begin n_fail++; $display("FAIL c12_en_cycles: got %0d required 12", en_cnt12 - e0); end
        if (bitq12.size() >= b0 + 12) for (int i = 0; i < 12; i++) v[i] = bitq12[b0 + i];
        n_cmp++;
        if (v !== 12'hFFF) begin n_fail++; $display("FAIL c12_bits: got %h required fff", v); end
        r0 = rbq12.size();
        load12(8'h00, 8'h00);
        n_cmp++;
        if (rbq12.size() - r0 !== 2) begin n_fail++; $display("FAIL c12_rb_count: got %0d required 2", rbq12.size() - r0); end
        if (rbq12.size() - r0 >= 2) begin
            n_cmp++;
            if (rbq12[r0] !== 8'hFF) begin n_fail++; $display("FAIL c12_rb_word0: got %h required ff", rbq12[r0]); end
            n_cmp++;
            if (rbq12[r0 + 1] !== 8'h0F) begin n_fail++; $display("FAIL c12_rb_word1: got %h required 0f", rbq12[r0 + 1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_readback();
        test_gap();
        test_abort();
        test_reset_mid();
        test_chain12();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 16, giving the total bits in the target configuration chain.
REQ-002 The block SHALL have parameter WORD_W, default 8, giving the width of each host word.
REQ-003 Port config_clk  in  1  shall be the single clock; all state updates on its rising edge.
REQ-004 Port config_rst_n  in  1  shall be the reset: asynchronous, active-low.
REQ-005 Port start  in  1  shall be a one-cycle request to begin a load.
REQ-006 Port abort  in  1  shall cancel an in-progress load.
REQ-007 Port s_data  in  WORD_W  shall carry a host configuration word.
REQ-008 Port s_valid  in  1  shall mark s_data valid.
REQ-009 Port s_ready  out  1  shall mark that the block accepts a word this cycle.
REQ-010 Port cfg_out  out  1  shall drive the chain's serial config_in.
REQ-011 Port cfg_en  out  1  shall drive the chain's config_en.
REQ-012 Port cfg_ret  in  1  shall receive the chain's serial config_out.
REQ-013 Port rb_data  out  WORD_W  shall carry readback bits shifted out of the chain.
REQ-014 Port rb_valid  out  1  shall pulse for one cycle when rb_data is valid.
REQ-015 Port busy  out  1  shall be high in any state except IDLE.
REQ-016 Port done  out  1  shall pulse for one cycle on load completion.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_WORD, SHIFT and DONE.
REQ-018 IDLE SHALL go to WAIT_WORD on start=1; start SHALL be ignored in every other state.
REQ-019 s_ready SHALL be 1 only in WAIT_WORD, and s_valid SHALL be ignored in every other state.
REQ-020 A transfer is s_valid&s_ready; it SHALL latch s_data and enter SHIFT on the next cycle.
REQ-021 In SHIFT the block SHALL drive cfg_en=1 for one cycle per bit, with cfg_out = the latched word's LSB first.
REQ-022 cfg_out and cfg_en SHALL be registered outputs; each SHIFT cycle SHALL move exactly one bit into the chain at its ending edge.
REQ-023 The number of bits shifted from a word SHALL be min(WORD_W, bits remaining); the number of words SHALL be ceil(CHAIN_LEN/WORD_W); unused upper bits of the last word SHALL be discarded.
REQ-024 After a word's final bit: if bits remain, the FSM SHALL go to WAIT_WORD, else to DONE.
REQ-025 Outside SHIFT, cfg_en SHALL be 0 and cfg_out SHALL hold its last value; host stalls SHALL insert no extra shifts.
REQ-026 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide, SHALL count total shifted bits, and SHALL never exceed CHAIN_LEN.
REQ-027 In each SHIFT cycle the block SHALL sample cfg_ret into a readback register, LSB first.
REQ-028 rb_valid SHALL pulse the cycle after WORD_W bits are collected, or after the final partial word; the upper bits of a partial word SHALL be 0.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with cfg_en=0 from that edge, no done, no rb_valid for a partial word, and counters cleared.
REQ-031 If abort and start occur in the same cycle in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-032 A one-word load with CHAIN_LEN<WORD_W SHALL shift CHAIN_LEN bits then go to DONE.

Reset
REQ-033 With config_rst_n=0, the FSM SHALL be in IDLE and s_ready, cfg_out, cfg_en, rb_data, rb_valid, busy and done SHALL all be 0, without waiting for a clock edge.
REQ-034 A reset asserted mid-load SHALL drop cfg_en immediately, leaving the chain partially loaded; a new start SHALL be required after reset.

Verification
REQ-035 CHAIN_LEN=16: start, words 0xA5 then 0x3C with s_valid held -> cfg_out 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; cfg_en high exactly 16 cycles; done pulses once.
REQ-036 Reload of 0x00,0x00 with cfg_ret from a 16-bit chain model -> rb_data 0xA5 then 0x3C, each with one rb_valid pulse.
REQ-037 5-cycle s_valid gap between words -> cfg_en low and cfg_out stable during the gap; still exactly 16 shifts.
REQ-038 CHAIN_LEN=12, words 0xFF,0xFF -> 12 shift cycles; second rb_valid shows upper 4 bits 0.
REQ-039 abort at bit 5 -> cfg_en=0 and busy=0 next cycle, no done; start while busy -> no effect.
REQ-040 config_rst_n low mid-SHIFT -> all outputs 0 before the next clock edge; start after reset -> clean 16-bit load.
